// File: rtl/nubus_slave.sv
// rtl/nubus_slave.sv - NuBus single-beat slave front-end for the on-card memory block
`timescale 1ns/1ps
module nubus_slave #(
    parameter int         TIMEOUT     = 15,
    parameter logic [1:0] WAIT_CLOCKS = 2'd0
) (
    input  logic        nub_clk,
    input  logic        nub_reset,
    input  logic [3:0]  nub_id_n,
    input  logic        nub_start_n,
    input  logic [31:0] nub_ad_n_i,
    output logic [31:0] nub_ad_n_o,
    output logic        nub_ad_oe,
    input  logic [1:0]  nub_tm_n_i,
    output logic [1:0]  nub_tm_n_o,
    output logic        nub_tm_oe,
    output logic        nub_ack_n_o,
    output logic        nub_ack_oe,
    output logic        mem_valid,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_myslot,
    output logic        mem_myexp,
    output logic [1:0]  mem_wait_clocks,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_MEM, S_ACK} state_t;

    state_t      r_state, w_next;
    logic        w_err;
    logic [3:0]  w_id;
    logic [31:0] w_a;
    logic        w_myslot, w_myexp, w_capture;
    logic        r_pend, r_p_wr, r_p_slot, r_p_exp;
    logic [31:0] r_p_addr;
    logic [3:0]  r_p_strb;
    logic [7:0]  r_cnt;
    logic        r_mem_valid, r_myslot, r_myexp;
    logic [3:0]  r_mem_write;
    logic [31:0] r_mem_addr, r_mem_wdata, r_ad_n;
    logic        r_ad_oe, r_tm_oe, r_ack_n, r_ack_oe;
    logic [1:0]  r_tm_n;

    assign w_id     = ~nub_id_n;
    assign w_a      = ~nub_ad_n_i;
    assign w_myslot = (w_a[31:28] == 4'hF) && (w_a[27:24] == w_id);
    assign w_myexp  = (w_a[31:28] == w_id) && (w_id != 4'hF) && (w_id != 4'h0);
    // Starts are only registered while idle with nothing pending, so a start
    // seen on the ACK->IDLE edge is dropped.
    assign w_capture = (r_state == S_IDLE) && !r_pend;

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            r_pend   <= 1'b0;
            r_p_wr   <= 1'b0;
            r_p_slot <= 1'b0;
            r_p_exp  <= 1'b0;
            r_p_addr <= 32'h0;
            r_p_strb <= 4'h0;
        end else if (w_capture) begin
            r_pend   <= !nub_start_n && (w_myslot || w_myexp);
            r_p_wr   <= !nub_tm_n_i[1];
            r_p_slot <= w_myslot;
            r_p_exp  <= w_myexp;
            r_p_addr <= {w_a[31:2], 2'b00};
            r_p_strb <= nub_tm_n_i[0] ? 4'b1111 : (4'b0001 << w_a[1:0]);
        end else begin
            r_pend   <= 1'b0;
        end
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:  if (r_pend) w_next = r_p_wr ? S_WDATA : S_MEM;
            S_WDATA: w_next = S_MEM;
            S_MEM: begin
                if (mem_ready) begin
                    w_next = S_ACK;
                end else if (r_cnt >= 8'(TIMEOUT - 1)) begin
                    w_next = S_ACK;
                    w_err  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            r_cnt       <= 8'h0;
            r_mem_valid <= 1'b0;
            r_mem_write <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_myslot    <= 1'b0;
            r_myexp     <= 1'b0;
            r_ack_n     <= 1'b1;
            r_ack_oe    <= 1'b0;
            r_tm_oe     <= 1'b0;
            r_tm_n      <= 2'b11;
            r_ad_oe     <= 1'b0;
            r_ad_n      <= 32'hFFFF_FFFF;
        end else begin
            if (r_state != S_MEM)    r_cnt <= 8'h0;
            else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'h1;

            if (r_state == S_IDLE && r_pend) begin
                r_mem_addr  <= r_p_addr;
                r_mem_write <= r_p_wr ? r_p_strb : 4'h0;
                r_myslot    <= r_p_slot;
                r_myexp     <= r_p_exp;
            end
            if (r_state == S_WDATA) r_mem_wdata <= w_a;

            r_mem_valid <= (w_next == S_MEM);

            if (w_next == S_ACK) begin
                r_ack_n  <= 1'b0;
                r_ack_oe <= 1'b1;
                r_tm_oe  <= 1'b1;
                r_tm_n   <= w_err ? 2'b01 : 2'b00;
                r_ad_oe  <= (r_mem_write == 4'h0);
                // Error reads return all-ones data, i.e. all-zero on the active-low bus.
                if (r_mem_write != 4'h0) r_ad_n <= 32'hFFFF_FFFF;
                else if (w_err)          r_ad_n <= 32'h0;
                else                     r_ad_n <= ~mem_rdata;
            end else begin
                r_ack_n  <= 1'b1;
                r_ack_oe <= 1'b0;
                r_tm_oe  <= 1'b0;
                r_tm_n   <= 2'b11;
                r_ad_oe  <= 1'b0;
                r_ad_n   <= 32'hFFFF_FFFF;
            end
        end
    end

    assign mem_valid       = r_mem_valid;
    assign mem_write       = r_mem_write;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_myslot      = r_myslot;
    assign mem_myexp       = r_myexp;
    assign mem_wait_clocks = WAIT_CLOCKS;
    assign nub_ack_n_o     = r_ack_n;
    assign nub_ack_oe      = r_ack_oe;
    assign nub_tm_oe       = r_tm_oe;
    assign nub_tm_n_o      = r_tm_n;
    assign nub_ad_oe       = r_ad_oe;
    assign nub_ad_n_o      = r_ad_n;
endmodule

// File: doc/nubus_slave.md
# nubus_slave

Upstream NuBus slave front-end for the on-card memory block. Samples NuBus start cycles, decodes slot and expansion (super-slot) space against the geographic slot ID, and converts each single-beat transfer into a `mem_valid`/`mem_write`/`mem_addr`/`mem_wdata` request. Waits for `mem_ready` (or a timeout), then returns read data and the ack/status cycle on the bus. Block transfers, try-again and attention cycles are not supported.

## Interface
- `TIMEOUT`, 15: MEM-state cycles before a forced error ack; range 2..255.
- `WAIT_CLOCKS`, 2'd0: constant driven on `mem_wait_clocks`.
- `nub_clk` in 1: single clock; all state changes on its rising edge.
- `nub_reset` in 1: asynchronous, active-high reset.
- `nub_id_n` in 4: slot ID, active low; `id = ~nub_id_n`.
- `nub_start_n` in 1: start strobe, active low.
- `nub_ad_n_i` in 32: AD bus as sampled, active low.
- `nub_ad_n_o` out 32: AD drive value, active low.
- `nub_ad_oe` out 1: AD output enable.
- `nub_tm_n_i` in 2: {TM1,TM0} sampled, active low.
- `nub_tm_n_o` out 2: ack status drive.
- `nub_tm_oe` out 1: TM output enable.
- `nub_ack_n_o` out 1: ack drive, active low.
- `nub_ack_oe` out 1: ack output enable.
- `mem_valid` out 1: memory request.
- `mem_write` out 4: byte write strobes; 0 = read.
- `mem_addr` out 32: byte address.
- `mem_wdata` out 32: write data.
- `mem_myslot` / `mem_myexp` out 1 each: latched decode flags.
- `mem_wait_clocks` out 2: = `WAIT_CLOCKS`.
- `mem_rdata` in 32: read data (Z lanes possible on written lanes; ignored on writes).
- `mem_ready` in 1: request complete.

## Operation
- Address `a = ~nub_ad_n_i` at start. myslot: `a[31:28]==4'hF && a[27:24]==id`. myexp: `a[31:28]==id`, `id != 4'hF` and `id != 0`. Select = myslot | myexp.
- Transfer type: write when `nub_tm_n_i[1]==0`. `nub_tm_n_i[0]==1` → word, strobes 4'b1111. `nub_tm_n_i[0]==0` → byte, strobe bit `a[1:0]` (lane 0 = bits 7:0).
- `mem_addr = {a[31:2],2'b00}` latched; `mem_write` latched strobes for writes, 4'b0000 for reads.
- States:
  - IDLE: start sampled with select → writes to WDATA, reads to MEM; unselected starts ignored.
  - WDATA: one cycle; capture `mem_wdata = ~nub_ad_n_i` at its end; → MEM.
  - MEM: `mem_valid=1`; `mem_ready` sampled high → ACK (status OK; read: latch `mem_rdata`); counter reaching `TIMEOUT` → ACK (status ERR).
  - ACK: one cycle; `nub_ack_n_o=0`, `nub_ack_oe=1`, `nub_tm_oe=1`, `nub_tm_n_o` = 2'b00 OK / 2'b01 ERR; for reads `nub_ad_oe=1`, `nub_ad_n_o = ~rdata` (ERR: rdata = 32'hFFFFFFFF). → IDLE.
- Starts in any non-IDLE state ignored (single outstanding transfer).
- Timeout counter 8 bits, cleared on MEM entry, saturates; never wraps.
- Reset (any state, mid-transfer included): IDLE immediately; all enables 0, `nub_ack_n_o=1`, `nub_tm_n_o=2'b11`, `nub_ad_n_o=32'hFFFFFFFF`, `mem_valid=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, myslot/myexp 0, counter 0. No partial ack after reset.

## Timing
- Edge 0 = edge sampling start.
- Read, `mem_ready` in first MEM cycle: MEM during cycle 1, ACK during cycle 2, IDLE from edge 3. Min read latency start→ack = 2 cycles.
- Write: WDATA cycle 1, MEM cycle 2, ACK cycle 3. Min 3 cycles.
- Each extra MEM cycle before `mem_ready` adds one cycle.
- `mem_valid` held continuously through MEM; `mem_addr/mem_write/mem_wdata` stable from MEM entry until next accepted start; `mem_valid` drops the edge ACK is entered.
- All outputs registered except `mem_wait_clocks`.
- Next start accepted no earlier than the edge ending ACK (back-to-back allowed: start sampled at ACK→IDLE edge is not accepted; first accepted at following edge).
- Error ack asserted at the edge where count reaches `TIMEOUT`, i.e. ACK during MEM cycle `TIMEOUT+1`.

## Test plan
- id=4'h9: word write start `a=32'hF9000010`, TM=write/word, data 32'hDEADBEEF → cycle 2 `mem_valid=1, mem_write=4'b1111, mem_addr=32'hF9000010, mem_wdata=32'hDEADBEEF, mem_myslot=1`; ack low cycle 3, tm 2'b00.
- Word read at 32'hF9000010 with memory holding 32'hDEADBEEF, ready same cycle → ack cycle 2, `nub_ad_n_o=32'h21524110`, `nub_ad_oe=1`.
- Byte write `a=32'h90000003`, data 32'h000000AB → `mem_write=4'b1000`, `mem_myexp=1`, `mem_addr=32'h90000000`.
- Start to `32'hFA000000` (id 9) → no `mem_valid`, no ack, outputs stay at reset values.
- `mem_ready` held low, TIMEOUT=15 → ACK in MEM cycle 16, status 2'b01, read data 32'hFFFFFFFF; new start accepted afterwards.
- Assert `nub_reset` during MEM → same-cycle `mem_valid=0`, no ack; following read completes normally.
